dff_load_arbiter: RTL

- Round-robin arbiter that shares one WIDTH-bit D-register (Q_out/Qb_out) between NUM_REQ requesters.
- A requester raises req, holds its data, and receives a grant, then a one-cycle ack once its data has been captured.
- Sits in front of the team's D flip-flop storage and sequences every load and clear into it.

---
 rtl/dff_load_arbiter_if.sv | 43 ++++
 rtl/dff_load_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/dff_load_arbiter_if.sv
// ---------------------------------------------------------------------------
// dff_load_arbiter_if
//   Bundle of the requester-side bus for the shared D-register arbiter.
//   master : requester side (drives req/d_in/clr, observes grant/ack/register)
//   slave  : arbiter side   (observes req/d_in/clr, drives grant/ack/register)
//   Signals:
//     req      [NUM_REQ]        level request per requester, held until ack
//     d_in     [NUM_REQ*WIDTH]  requester i data at [i*WIDTH +: WIDTH]
//     clr                       synchronous clear of the shared register
//     gnt      [NUM_REQ]        registered one-hot grant
//     ack      [NUM_REQ]        one-cycle completion pulse
//     owner    [OWN_W]          current/last granted requester index
//     Q_out    [WIDTH]          shared register contents
//     Qb_out   [WIDTH]          complement of Q_out
//     load_cnt [CNT_W]          wrapping count of completed loads
// ---------------------------------------------------------------------------
interface dff_load_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 8
);
  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] d_in;
  logic                     clr;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       ack;
  logic [OWN_W-1:0]         owner;
  logic [WIDTH-1:0]         Q_out;
  logic [WIDTH-1:0]         Qb_out;
  logic [CNT_W-1:0]         load_cnt;

  modport master (
    output req, d_in, clr,
    input  gnt, ack, owner, Q_out, Qb_out, load_cnt
  );

  modport slave (
    input  req, d_in, clr,
    output gnt, ack, owner, Q_out, Qb_out, load_cnt
  );
endinterface

// File: rtl/dff_load_arbiter.sv
// ---------------------------------------------------------------------------
// dff_load_arbiter
//   Round-robin arbiter sequencing loads and clears of one shared WIDTH-bit
//   D-register among NUM_REQ requesters. One load completes at most every
//   three cycles (IDLE -> GRANT -> LOAD).
//   Ports:
//     clock  : rising-edge clock
//     reset  : asynchronous active-low reset
//     bus    : dff_load_arbiter_if.slave (request/data in, grant/ack/register out)
// ---------------------------------------------------------------------------
module dff_load_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 8
) (
  input  logic                clock,
  input  logic                reset,
  dff_load_arbiter_if.slave   bus
);
  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [OWN_W-1:0]   owner_q;
  logic [OWN_W-1:0]   ptr_q;
  logic [WIDTH-1:0]   reg_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [OWN_W-1:0]   win_d;
  logic [OWN_W-1:0]   idx_d;
  logic               found_d;
  logic [WIDTH-1:0]   slice_w [NUM_REQ];

  // Per-requester data slices, so the captured slice is a plain mux on owner.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign slice_w[gi] = bus.d_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Winner search starts at ptr and wraps; NUM_REQ is a power of two so the
  // natural OWN_W-bit overflow of ptr+i gives the modulo for free.
  always_comb begin
    win_d   = ptr_q;
    idx_d   = ptr_q;
    found_d = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_d = ptr_q + OWN_W'(i);
      if (!found_d && bus.req[idx_d]) begin
        win_d   = idx_d;
        found_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      reg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      ack_q <= '0;
      // clr wins over any capture scheduled below in GRANT.
      if (bus.clr) begin
        reg_q <= '0;
      end
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            gnt_q   <= NUM_REQ'(1) << win_d;
            owner_q <= win_d;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          gnt_q   <= '0;
          state_q <= IDLE;
          // Capture and completion happen on the same edge so ack, Q_out and
          // load_cnt all become visible together in the LOAD cycle.
          if (!bus.clr && bus.req[owner_q]) begin
            reg_q          <= slice_w[owner_q];
            ack_q[owner_q] <= 1'b1;
            cnt_q          <= cnt_q + 1'b1;
            ptr_q          <= owner_q + 1'b1;
            state_q        <= LOAD;
          end
        end
        LOAD: begin
          // Always return to IDLE so a held req is re-arbitrated fresh.
          state_q <= IDLE;
        end
        default: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.owner    = owner_q;
  assign bus.Q_out    = reg_q;
  assign bus.Qb_out   = ~reg_q;
  assign bus.load_cnt = cnt_q;

endmodule
